// File: rtl/rgb_seq_pkg.sv
// Shared types and helpers for the RGB colour sequencer: colour layout, FSM states,
// reset palette contents and the per-channel fade step.
package rgb_seq_pkg;

  localparam int PWM_BITS = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FADE = 2'd2
  } state_t;

  function automatic color_t default_palette(input int k);
    color_t c;
    case (2'(k % 4))
      2'd0:    c = 24'hFF0000;
      2'd1:    c = 24'h00FF00;
      2'd2:    c = 24'h0000FF;
      default: c = 24'hFFFFFF;
    endcase
    return c;
  endfunction

  // One saturating step toward the target; never wraps past 0 or 255.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_pwm_gen.sv
// PWM timebase for the RGB driver: prescaler, 8-bit period counter, period-end strobe
// and three registered duty comparators. Everything is held cleared while run is low.
module rgb_pwm_gen
  import rgb_seq_pkg::*;
#(
  parameter int PRESCALE = 94
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [23:0] duty,
  output logic [2:0]  pwm_out,
  output logic        period_end,
  output logic        frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       presc_r;
  logic [PWM_BITS-1:0] cnt_r;
  logic                tick_s;

  // Prescaler terminal count and end-of-period strobe.
  always_comb begin
    tick_s     = run && (presc_r == PW'(PRESCALE - 1));
    period_end = tick_s && (cnt_r == 8'hFF);
  end

  // Timebase counters and registered comparator outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r    <= {PW{1'b0}};
      cnt_r      <= 8'd0;
      pwm_out    <= 3'b000;
      frame_tick <= 1'b0;
    end else if (!run) begin
      presc_r    <= {PW{1'b0}};
      cnt_r      <= 8'd0;
      pwm_out    <= 3'b000;
      frame_tick <= 1'b0;
    end else begin
      presc_r    <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
      if (tick_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
      frame_tick <= period_end;
      pwm_out    <= {duty[7:0] > cnt_r, duty[15:8] > cnt_r, duty[23:16] > cnt_r};
    end
  end

endmodule

// File: rtl/rgb_color_sequencer.sv
// Palette-driven colour sequencer for SB_RGBA_DRV: holds each palette colour for a
// programmable number of PWM periods, then fades linearly to the next entry.
module rgb_color_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int PRESCALE   = 94,
  parameter int NUM_COLORS = 4,
  parameter int IDX_W      = $clog2(NUM_COLORS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      hold_len,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [23:0]      cfg_color,
  output logic [2:0]       pwm_out,
  output logic             led_en,
  output logic [IDX_W-1:0] cur_index,
  output logic             fading,
  output logic             frame_tick
);

  // Storage is rounded up to a power of two; entries at or above NUM_COLORS are
  // writable but never selected, so such writes have no visible effect.
  localparam int DEPTH = 2 ** IDX_W;

  color_t           palette_r [DEPTH];
  state_t           state_r;
  color_t           duty_r;
  color_t           target_r;
  logic [15:0]      hold_cnt_r;

  logic             run_s;
  logic             wr_en_s;
  logic             period_end_s;
  logic [15:0]      hold_load_s;
  logic [IDX_W-1:0] nxt_idx_s;
  color_t           nxt_color_s;
  color_t           cur_color_s;
  color_t           step_s;

  // Next-entry lookup; reads forward a palette write landing on the same edge.
  always_comb begin
    run_s       = enable && (state_r != IDLE);
    wr_en_s     = cfg_valid && cfg_ready;
    hold_load_s = (hold_len == 16'd0) ? 16'd1 : hold_len;
    if (cur_index == IDX_W'(NUM_COLORS - 1)) begin
      nxt_idx_s = {IDX_W{1'b0}};
    end else begin
      nxt_idx_s = cur_index + IDX_W'(1);
    end
    if (wr_en_s && (cfg_addr == nxt_idx_s)) begin
      nxt_color_s = cfg_color;
    end else begin
      nxt_color_s = palette_r[nxt_idx_s];
    end
    if (wr_en_s && (cfg_addr == cur_index)) begin
      cur_color_s = cfg_color;
    end else begin
      cur_color_s = palette_r[cur_index];
    end
    step_s.r = step_toward(duty_r.r, target_r.r);
    step_s.g = step_toward(duty_r.g, target_r.g);
    step_s.b = step_toward(duty_r.b, target_r.b);
  end

  // Sequencer FSM, palette storage and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        palette_r[k] <= default_palette(k);
      end
      state_r    <= IDLE;
      duty_r     <= 24'h000000;
      target_r   <= 24'h000000;
      hold_cnt_r <= 16'd0;
      cur_index  <= {IDX_W{1'b0}};
      led_en     <= 1'b0;
      fading     <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      if (wr_en_s) begin
        palette_r[cfg_addr] <= cfg_color;
      end
      if (!enable) begin
        state_r    <= IDLE;
        duty_r     <= 24'h000000;
        target_r   <= 24'h000000;
        hold_cnt_r <= 16'd0;
        cur_index  <= {IDX_W{1'b0}};
        led_en     <= 1'b0;
        fading     <= 1'b0;
        cfg_ready  <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            state_r    <= HOLD;
            duty_r     <= cur_color_s;
            hold_cnt_r <= hold_load_s;
            led_en     <= 1'b1;
            fading     <= 1'b0;
            cfg_ready  <= 1'b1;
          end
          HOLD: begin
            if (period_end_s) begin
              duty_r <= cur_color_s;
              if (hold_cnt_r <= 16'd1) begin
                state_r   <= FADE;
                target_r  <= nxt_color_s;
                fading    <= 1'b1;
                cfg_ready <= 1'b0;
              end else begin
                hold_cnt_r <= hold_cnt_r - 16'd1;
              end
            end
          end
          FADE: begin
            if (period_end_s) begin
              duty_r <= step_s;
              if (step_s == target_r) begin
                state_r    <= HOLD;
                cur_index  <= nxt_idx_s;
                hold_cnt_r <= hold_load_s;
                fading     <= 1'b0;
                cfg_ready  <= 1'b1;
              end
            end
          end
          default: begin
            state_r   <= IDLE;
            led_en    <= 1'b0;
            fading    <= 1'b0;
            cfg_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  rgb_pwm_gen #(
    .PRESCALE (PRESCALE)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_s),
    .duty       (duty_r),
    .pwm_out    (pwm_out),
    .period_end (period_end_s),
    .frame_tick (frame_tick)
  );

endmodule

// File: doc/rgb_color_sequencer.md
Name: rgb_color_sequencer

Overview:
Generates the three PWM control signals (RGB0PWM..RGB2PWM) and the LED enable for the iCE40 SB_RGBA_DRV hard driver. It steps through a small programmable palette of 24-bit colours, holding each colour and then linearly fading to the next. It sits between the on-chip SB_HFOSC clock domain logic and the SB_RGBA_DRV instance. It replaces ad-hoc counter-bit decoding with a configurable, glitch-free sequencer.

Parameters:
PRESCALE, 94, clk cycles per PWM count step (24 MHz / (256*94) ≈ 1 kHz PWM); legal 1..65535
NUM_COLORS, 4, palette entries; legal 2..8
IDX_W, 2, index width = clog2(NUM_COLORS); derived, not overridden

Ports:
clk  in  1  system clock (SB_HFOSC CLKHF)
rst_n  in  1  asynchronous active-low reset
enable  in  1  run sequencer; 0 forces IDLE
hold_len  in  16  PWM periods to hold each colour; sampled on HOLD entry; 0 treated as 1
cfg_valid  in  1  palette write request
cfg_ready  out  1  palette write may be accepted
cfg_addr  in  IDX_W  palette entry to write
cfg_color  in  24  {R[23:16],G[15:8],B[7:0]}
pwm_out  out  3  [0]=R→RGB0PWM, [1]=G→RGB1PWM, [2]=B→RGB2PWM
led_en  out  1  to RGBLEDEN/CURREN
cur_index  out  IDX_W  palette entry currently held / faded from
fading  out  1  high in FADE
frame_tick  out  1  one-cycle pulse at each PWM period end

Behaviour:
- Reset: pwm_out=0, led_en=0, cur_index=0, fading=0, frame_tick=0, cfg_ready=1, duty=0, counters=0, state=IDLE; palette entry k loaded with k%4: 0→FF0000, 1→00FF00, 2→0000FF, 3→FFFFFF.
- Timebase: prescale counter 0..PRESCALE-1; tick when it equals PRESCALE-1. 8-bit pwm_cnt increments on tick and wraps 255→0. period_end = tick && pwm_cnt==255. frame_tick is registered period_end. Timebase is held cleared in IDLE.
- PWM: pwm_out[i] is registered (duty[i] > pwm_cnt). Latency is 1 clk. duty 0 gives always low; duty 255 gives 255/256 high. duty changes only at period_end (glitch-free), except on HOLD entry from IDLE.
- States:
  - IDLE: led_en=0, pwm_out=0, cur_index=0. enable=1 → HOLD next cycle, duty←palette[0], hold counter←hold_len.
  - HOLD: led_en=1. Each period_end decrements the hold counter. When the count expires on a period_end → FADE, target←palette[(cur_index+1) wrapped at NUM_COLORS-1→0].
  - FADE: fading=1. At each period_end, each duty channel steps ±1 toward target; channels already at target stay. After the step, if all three channels equal target → HOLD, cur_index←next, hold counter←hold_len. Fade lasts max channel difference periods, minimum 1 period (identical colours still take 1 period).
- enable=0 in any state → IDLE on next clk: pwm_out=0 and led_en=0 that same edge, cur_index=0, timebase cleared.
- Config handshake: a write is accepted on a cycle with cfg_valid && cfg_ready, and palette[cfg_addr] is updated at that edge. cfg_ready=0 in FADE, 1 otherwise. In HOLD, a write to cur_index updates duty at the next period_end.
- cfg_addr ≥ NUM_COLORS: accepted and ignored.
- Simultaneous write and FADE entry on the same edge: the write is accepted (cfg_ready was 1) and the target uses the newly written value.
- Arithmetic: duty ±1 never wraps; comparison is unsigned 8-bit.

Decomposition:
- Package rgb_seq_pkg: color_t (24-bit packed R/G/B), state_t enum {IDLE,HOLD,FADE}, DEFAULT_PALETTE constant function, PWM_BITS=8.
- Sub-module rgb_pwm_gen: prescaler, pwm_cnt, period_end/frame_tick, and three registered comparators. Inputs are duty[3] and run; outputs are pwm_out and period_end. The sequencer FSM and palette stay in the top.

Test Plan:
- Reset then enable=1, PRESCALE=1, hold_len=2 → next cycle led_en=1; pwm_out[0] high 255 of every 256 clks, [1],[2] low; FADE entered at clk 512 after enable.
- FADE FF0000→00FF00 → 255 periods of fading=1; R duty decrements and G duty increments by 1 per period; cur_index=1 on exit; frame_tick every 256 clks.
- Write entry 1 = FF0000 while holding entry 0 → fade lasts exactly 1 period, and cur_index becomes 1.
- cfg_valid during FADE → cfg_ready=0 and palette unchanged; write completes on the first HOLD cycle.
- Index wrap: NUM_COLORS=4, run through entry 3 → next target palette[0], cur_index 3→0.
- enable dropped mid-FADE, then rst_n pulsed mid-HOLD → pwm_out=0 and led_en=0 on the next edge (enable) and immediately on reset (async); restart begins at entry 0 with default palette after reset.
